// File: rtl/capture_trigger_ctrl.sv
// Capture sequencer for the ADC buffers: arbitrates ext/int/soft triggers, strobes capture,
// waits for all buffers (or a timeout), holds the event for the PS, then applies a holdoff before re-arming.
module capture_trigger_ctrl #(
  parameter int NUM_CH      = 8,
  parameter int HOLDOFF_W   = 16,
  parameter int TIMEOUT_CYC = 65536,
  parameter int CNT_W       = 16
) (
  input  logic                 adc_div2_clk,
  input  logic                 rst,
  input  logic                 enable_i,
  input  logic                 ext_trig_i,
  input  logic                 int_trig_i,
  input  logic                 soft_trig_i,
  input  logic [2:0]           trig_mask_i,
  input  logic [HOLDOFF_W-1:0] holdoff_i,
  input  logic                 clear_i,
  input  logic [NUM_CH-1:0]    done_i,
  output logic                 capture_o,
  output logic                 busy_o,
  output logic                 trig_pending_o,
  output logic [2:0]           trig_source_o,
  output logic                 timeout_o,
  output logic [CNT_W-1:0]     trig_count_o,
  output logic [CNT_W-1:0]     missed_count_o
);

  localparam int              TO_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_WAIT_DONE,
    S_PENDING,
    S_HOLDOFF
  } state_t;

  state_t                 state_q, state_d;
  logic                   capture_q;
  logic                   busy_q;
  logic                   pending_q;
  logic [2:0]             source_q;
  logic                   timeout_q;
  logic [CNT_W-1:0]       trig_cnt_q;
  logic [CNT_W-1:0]       missed_cnt_q;
  logic [TO_W-1:0]        to_cnt_q;
  logic [HOLDOFF_W-1:0]   holdoff_q;

  logic [2:0] hit;
  logic       hit_any;
  logic       all_done;
  logic       accept;
  logic       to_fire;

  assign hit      = {soft_trig_i, int_trig_i, ext_trig_i} & trig_mask_i;
  assign hit_any  = |hit;
  assign all_done = &done_i;
  // Disable wins over a coincident trigger in ARMED.
  assign accept   = (state_q == S_ARMED) && enable_i && hit_any;
  // Completion on the last timeout cycle takes precedence over the timeout.
  assign to_fire  = (state_q == S_WAIT_DONE) && !all_done && (to_cnt_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (enable_i) state_d = S_ARMED;
      S_ARMED: begin
        if (!enable_i)    state_d = S_IDLE;
        else if (hit_any) state_d = S_CAPTURE;
      end
      S_CAPTURE:   state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (all_done || to_fire) state_d = S_PENDING;
      S_PENDING:   if (clear_i) state_d = S_HOLDOFF;
      S_HOLDOFF:   if (holdoff_q == '0) state_d = enable_i ? S_ARMED : S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge adc_div2_clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      capture_q    <= 1'b0;
      busy_q       <= 1'b0;
      pending_q    <= 1'b0;
      source_q     <= '0;
      timeout_q    <= 1'b0;
      trig_cnt_q   <= '0;
      missed_cnt_q <= '0;
      to_cnt_q     <= '0;
      holdoff_q    <= '0;
    end else begin
      state_q   <= state_d;
      // Strobe trails the CAPTURE state by one cycle, giving a fixed hit-to-strobe latency of two edges.
      capture_q <= (state_q == S_CAPTURE);
      busy_q    <= (state_d inside {S_CAPTURE, S_WAIT_DONE, S_PENDING, S_HOLDOFF});
      pending_q <= (state_d == S_PENDING);

      if (accept) begin
        source_q   <= hit;
        trig_cnt_q <= trig_cnt_q + 1'b1;
      end

      if (hit_any && (state_q != S_ARMED) && (missed_cnt_q != '1))
        missed_cnt_q <= missed_cnt_q + 1'b1;

      if (state_q == S_CAPTURE)
        to_cnt_q <= '0;
      else if ((state_q == S_WAIT_DONE) && !all_done)
        to_cnt_q <= to_cnt_q + 1'b1;

      if (to_fire)
        timeout_q <= 1'b1;
      else if (clear_i)
        timeout_q <= 1'b0;

      if ((state_q == S_PENDING) && clear_i)
        holdoff_q <= holdoff_i;
      else if ((state_q == S_HOLDOFF) && (holdoff_q != '0))
        holdoff_q <= holdoff_q - 1'b1;
    end
  end

  assign capture_o      = capture_q;
  assign busy_o         = busy_q;
  assign trig_pending_o = pending_q;
  assign trig_source_o  = source_q;
  assign timeout_o      = timeout_q;
  assign trig_count_o   = trig_cnt_q;
  assign missed_count_o = missed_cnt_q;

endmodule

// File: tb/tb_capture_trigger_ctrl.sv
// Bench for capture_trigger_ctrl: directed scenarios then random stimulus, every cycle compared
// against an event/deadline-based reference model.
module tb_capture_trigger_ctrl;

  localparam int NUM_CH      = 8;
  localparam int HOLDOFF_W   = 16;
  localparam int TIMEOUT_CYC = 16;
  localparam int CNT_W       = 4;
  localparam int MAX_CNT     = (1 << CNT_W) - 1;

  logic                 adc_div2_clk = 1'b0;
  logic                 rst;
  logic                 enable_i;
  logic                 ext_trig_i;
  logic                 int_trig_i;
  logic                 soft_trig_i;
  logic [2:0]           trig_mask_i;
  logic [HOLDOFF_W-1:0] holdoff_i;
  logic                 clear_i;
  logic [NUM_CH-1:0]    done_i;
  logic                 capture_o;
  logic                 busy_o;
  logic                 trig_pending_o;
  logic [2:0]           trig_source_o;
  logic                 timeout_o;
  logic [CNT_W-1:0]     trig_count_o;
  logic [CNT_W-1:0]     missed_count_o;

  capture_trigger_ctrl #(
    .NUM_CH(NUM_CH), .HOLDOFF_W(HOLDOFF_W), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)
  ) dut (
    .adc_div2_clk(adc_div2_clk), .rst(rst), .enable_i(enable_i),
    .ext_trig_i(ext_trig_i), .int_trig_i(int_trig_i), .soft_trig_i(soft_trig_i),
    .trig_mask_i(trig_mask_i), .holdoff_i(holdoff_i), .clear_i(clear_i), .done_i(done_i),
    .capture_o(capture_o), .busy_o(busy_o), .trig_pending_o(trig_pending_o),
    .trig_source_o(trig_source_o), .timeout_o(timeout_o),
    .trig_count_o(trig_count_o), .missed_count_o(missed_count_o)
  );

  always #5 adc_div2_clk = ~adc_div2_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase plus absolute deadlines measured in clock edges.
  localparam int P_IDLE = 0, P_ARM = 1, P_CAP = 2, P_WAIT = 3, P_PEND = 4, P_HOLD = 5;
  int         ph;
  int         cyc = 0;
  int         wait_start;
  int         release_at;
  logic       m_cap, m_busy, m_pend, m_to;
  logic [2:0] m_src;
  int         m_cnt, m_miss;

  task automatic model_reset();
    ph = P_IDLE; m_cap = 0; m_busy = 0; m_pend = 0; m_to = 0;
    m_src = 0; m_cnt = 0; m_miss = 0; wait_start = 0; release_at = 0;
  endtask

  task automatic model_step();
    logic [2:0] hit;
    cyc++;
    if (rst) begin
      model_reset();
      return;
    end
    hit   = {soft_trig_i, int_trig_i, ext_trig_i} & trig_mask_i;
    m_cap = (ph == P_CAP);
    if (ph != P_ARM && hit != 0 && m_miss < MAX_CNT) m_miss++;
    if (clear_i) m_to = 0;
    case (ph)
      P_IDLE: if (enable_i) ph = P_ARM;
      P_ARM: begin
        if (!enable_i) ph = P_IDLE;
        else if (hit != 0) begin
          m_src = hit;
          m_cnt = (m_cnt + 1) % (MAX_CNT + 1);
          ph    = P_CAP;
        end
      end
      P_CAP: begin wait_start = cyc; ph = P_WAIT; end
      P_WAIT: begin
        if (&done_i) ph = P_PEND;
        else if (cyc - wait_start == TIMEOUT_CYC) begin m_to = 1; ph = P_PEND; end
      end
      P_PEND: if (clear_i) begin release_at = cyc + int'(holdoff_i) + 1; ph = P_HOLD; end
      P_HOLD: if (cyc == release_at) ph = enable_i ? P_ARM : P_IDLE;
      default: ph = P_IDLE;
    endcase
    m_busy = (ph == P_CAP) || (ph == P_WAIT) || (ph == P_PEND) || (ph == P_HOLD);
    m_pend = (ph == P_PEND);
  endtask

  task automatic compare_all();
    chk("capture", capture_o, m_cap);
    chk("busy", busy_o, m_busy);
    chk("pending", trig_pending_o, m_pend);
    chk("source", trig_source_o, m_src);
    chk("timeout", timeout_o, m_to);
    chk("trig_count", trig_count_o, m_cnt);
    chk("missed", missed_count_o, m_miss);
  endtask

  task automatic step();
    @(posedge adc_div2_clk);
    model_step();
    @(negedge adc_div2_clk);
    compare_all();
  endtask

  // Called at a falling edge; asserts reset between edges and releases it one cycle later.
  task automatic async_reset();
    #2 rst = 1'b1;
    model_reset();
    #1 compare_all();
    chk("arst_busy", busy_o, 0);
    chk("arst_count", trig_count_o, 0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    rst = 1'b1; enable_i = 0; ext_trig_i = 0; int_trig_i = 0; soft_trig_i = 0;
    trig_mask_i = 3'b111; holdoff_i = 0; clear_i = 0; done_i = 0;
    repeat (2) step();
    chk("rst_pending", trig_pending_o, 0);
    rst = 1'b0;
    enable_i = 1; step(); step();

    // Basic ext trigger, done, clear with holdoff 4.
    ext_trig_i = 1; step(); ext_trig_i = 0;
    chk("t1_nocap", capture_o, 0);
    step();
    chk("t1_cap", capture_o, 1);
    chk("t1_src", trig_source_o, 3'b001);
    chk("t1_cnt", trig_count_o, 1);
    step();
    chk("t1_cap_once", capture_o, 0);
    repeat (4) step();
    done_i = 8'hFF; step();
    chk("t1_pend", trig_pending_o, 1);
    done_i = 0; holdoff_i = 4; clear_i = 1; step(); clear_i = 0;
    chk("t1_pend_clr", trig_pending_o, 0);
    repeat (4) step();
    chk("t1_busy_hold", busy_o, 1);
    step();
    chk("t1_busy_rel", busy_o, 0);

    // Simultaneous sources, soft masked out.
    trig_mask_i = 3'b011;
    ext_trig_i = 1; int_trig_i = 1; soft_trig_i = 1; step();
    ext_trig_i = 0; int_trig_i = 0; soft_trig_i = 0; step();
    chk("t2_cap", capture_o, 1);
    chk("t2_src", trig_source_o, 3'b011);
    chk("t2_cnt", trig_count_o, 2);
    done_i = 8'hFF; step();
    holdoff_i = 0; clear_i = 1; step(); clear_i = 0; done_i = 0; step();

    // Timeout, then done on the final timeout cycle.
    done_i = 8'h7F;
    int_trig_i = 1; step(); int_trig_i = 0; step();
    repeat (15) step();
    chk("t3_pend_early", trig_pending_o, 0);
    step();
    chk("t3_pend", trig_pending_o, 1);
    chk("t3_timeout", timeout_o, 1);
    clear_i = 1; step(); clear_i = 0;
    chk("t3_pend_clr", trig_pending_o, 0);
    chk("t3_to_clr", timeout_o, 0);
    step();
    int_trig_i = 1; step(); int_trig_i = 0; step();
    repeat (15) step();
    done_i = 8'hFF; step();
    chk("t3_done_pend", trig_pending_o, 1);
    chk("t3_done_wins", timeout_o, 0);
    clear_i = 1; step(); clear_i = 0; step();

    // Missed triggers in WAIT_DONE, PENDING, HOLDOFF.
    done_i = 0;
    int_trig_i = 1; step(); int_trig_i = 0; step();
    int_trig_i = 1; step(); int_trig_i = 0;
    done_i = 8'hFF; step();
    int_trig_i = 1; step(); int_trig_i = 0;
    holdoff_i = 3; clear_i = 1; step(); clear_i = 0;
    int_trig_i = 1; step(); int_trig_i = 0;
    chk("t4_missed", missed_count_o, 3);
    repeat (3) step();
    done_i = 0;

    // Enable dropped mid-capture, then disable coincident with a trigger.
    ext_trig_i = 1; step(); ext_trig_i = 0; step();
    enable_i = 0; repeat (3) step();
    done_i = 8'hFF; step();
    holdoff_i = 2; clear_i = 1; step(); clear_i = 0;
    repeat (3) step();
    chk("t5_idle_busy", busy_o, 0);
    done_i = 0;
    enable_i = 1; step();
    enable_i = 0; ext_trig_i = 1; step(); ext_trig_i = 0; step();
    chk("t5_nocap", capture_o, 0);
    chk("t5_missed", missed_count_o, 3);
    chk("t5_cnt", trig_count_o, 6);

    // Missed counter saturation.
    int_trig_i = 1; repeat (14) step();
    chk("t6_sat", missed_count_o, MAX_CNT);
    step(); int_trig_i = 0;
    chk("t6_sat_hold", missed_count_o, MAX_CNT);

    // Async reset mid-WAIT_DONE and mid-HOLDOFF.
    enable_i = 1; step();
    trig_mask_i = 3'b111;
    ext_trig_i = 1; step(); ext_trig_i = 0; step();
    repeat (3) step();
    async_reset();
    step();
    ext_trig_i = 1; step(); ext_trig_i = 0; step();
    chk("t7_cap", capture_o, 1);
    done_i = 8'hFF; step();
    holdoff_i = 10; clear_i = 1; step(); clear_i = 0;
    repeat (2) step();
    async_reset();
    done_i = 0;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      enable_i    = ($urandom_range(0, 19) != 0);
      ext_trig_i  = ($urandom_range(0, 4) == 0);
      int_trig_i  = ($urandom_range(0, 4) == 0);
      soft_trig_i = ($urandom_range(0, 4) == 0);
      trig_mask_i = 3'($urandom_range(0, 7));
      done_i      = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom);
      clear_i     = ($urandom_range(0, 5) == 0);
      holdoff_i   = HOLDOFF_W'($urandom_range(0, 6));
      step();
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/capture_trigger_ctrl.md
Name: capture_trigger_ctrl

Overview:
- Sequences the ADC capture buffers in the adc_div2_clk domain.
- Arbitrates three trigger sources: external/PS capture, internal trigger, and soft/periodic trigger.
- Issues a single capture strobe, then waits for all channel buffers to report done, flags the event to the PS, and waits for the PS clear.
- Applies a programmable holdoff before re-arming, and keeps trigger, missed-trigger and timeout status.

Parameters:
- NUM_CH, 8: number of capture buffers reporting done.
- HOLDOFF_W, 16: width of the holdoff count.
- TIMEOUT_CYC, 65536: maximum cycles in WAIT_DONE before a forced timeout.
- CNT_W, 16: width of the trigger and missed-trigger counters.

Ports:
- adc_div2_clk  in  1  block clock.
- rst  in  1  reset, asynchronous, active-high.
- enable_i  in  1  level; arms the controller.
- ext_trig_i  in  1  single-cycle pulse, already synchronised to adc_div2_clk.
- int_trig_i  in  1  single-cycle pulse from the internal trigger.
- soft_trig_i  in  1  single-cycle pulse, software/periodic trigger.
- trig_mask_i  in  3  per-source enable; bit0 ext, bit1 int, bit2 soft.
- holdoff_i  in  HOLDOFF_W  post-clear dead time in cycles; sampled on clear.
- clear_i  in  1  single-cycle pulse; event has been read out.
- done_i  in  NUM_CH  per-buffer capture-complete, level.
- capture_o  out  1  one-cycle capture strobe to the buffers.
- busy_o  out  1  high in CAPTURE, WAIT_DONE, PENDING and HOLDOFF.
- trig_pending_o  out  1  event ready for readout.
- trig_source_o  out  3  sources that fired on the accepted trigger; same bit order as the mask.
- timeout_o  out  1  sticky; a capture was forced out of WAIT_DONE by timeout.
- trig_count_o  out  CNT_W  accepted triggers, wrapping.
- missed_count_o  out  CNT_W  unmasked triggers arriving while not ARMED, saturating.

Behaviour:
- Reset value of every output is 0. The state machine resets to IDLE and all counters reset to 0. Reset may arrive in any state: it aborts immediately and no capture_o is emitted after it.
- Per-cycle trigger vector: hit = {soft_trig_i, int_trig_i, ext_trig_i} & trig_mask_i. A trigger is any bit of hit set.
- State IDLE:
  - Moves to ARMED the cycle after enable_i is seen high.
- State ARMED:
  - If enable_i is low, go to IDLE. Disable takes priority over a coincident trigger; that trigger is dropped and not counted as missed.
  - On any hit, go to CAPTURE. trig_source_o latches hit, so simultaneous sources all show as set bits. trig_count_o increments by 1.
- State CAPTURE (exactly 1 cycle):
  - capture_o = 1. Latency is fixed: a hit sampled at edge N gives capture_o high for the cycle following edge N+1.
  - Next state is WAIT_DONE; the timeout counter clears.
- State WAIT_DONE:
  - When &done_i = 1, go to PENDING.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYC-1, set timeout_o and go to PENDING.
  - If done completes on the same cycle the timeout would fire, done wins and timeout_o is not set.
- State PENDING:
  - trig_pending_o = 1.
  - On clear_i: load the holdoff counter from holdoff_i, drop trig_pending_o, and go to HOLDOFF.
- State HOLDOFF:
  - The counter decrements to 0. If holdoff_i is 0, exit on the next cycle.
  - At 0, go to ARMED if enable_i is high, otherwise IDLE.
- clear_i in any state other than PENDING is ignored. Exception: clear_i in any state also clears timeout_o.
- enable_i dropping during CAPTURE, WAIT_DONE, PENDING or HOLDOFF does not abort the capture. The sequence completes and exits to IDLE.
- missed_count_o increments by 1 on each cycle with any hit while in any state other than ARMED. Multiple sources on one cycle count once. The counter saturates at all-ones.
- trig_count_o wraps from all-ones to 0.
- trig_source_o holds its value until the next accepted trigger.
- busy_o is a registered decode of the state; it is 0 in IDLE and ARMED.

Test Plan:
- Reset, enable_i=1, mask=3'b111, ext pulse at cycle 10 -> capture_o high one cycle at 12, trig_source_o=3'b001. Set done_i=8'hFF at cycle 20 -> trig_pending_o=1 from 21. Pulse clear_i with holdoff_i=4 -> busy_o low and ARMED 5 cycles later; trig_count_o=1.
- Simultaneous ext and int pulses, mask=3'b011, plus a soft pulse -> one capture_o, trig_source_o=3'b011, trig_count_o increments by 1.
- Keep done_i=8'h7F after capture with TIMEOUT_CYC=16 -> trig_pending_o and timeout_o rise 16 cycles after capture. clear_i clears both. done_i=8'hFF on the final timeout cycle -> timeout_o stays 0.
- Three int pulses during WAIT_DONE/PENDING/HOLDOFF -> missed_count_o=3, no extra capture_o. Force missed_count_o to 16'hFFFF and pulse again -> stays 16'hFFFF.
- enable_i drops during WAIT_DONE -> done, then clear -> ends in IDLE. enable_i low coincident with ext pulse in ARMED -> IDLE, no capture_o, missed_count_o unchanged.
- Assert rst asynchronously mid-WAIT_DONE and mid-HOLDOFF -> all outputs 0 immediately. After release with enable_i=1 -> ARMED in 1 cycle, counters 0.
